vx_writeback_arbiter: RTL

- Arbitrates writeback traffic from NUM_REQS execute units (ALU, LSU, CSR, FPU, …) onto the single register-file writeback port of a core.
- Round-robin fairness is kept at instruction-packet granularity: a requester that has started a multi-beat packet (eop=0) holds the grant until its eop beat is accepted.
- The output is registered through a 2-entry skid buffer, so the block accepts one beat per cycle with no combinational path from out_ready to any in_ready.

---
 rtl/vx_writeback_arbiter_pkg.sv | 42 ++++
 rtl/wb_skid_buffer.sv | 57 +++++
 rtl/vx_writeback_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vx_writeback_arbiter_pkg.sv
// Shared writeback beat definition and field widths for the writeback arbiter.
// The field-width defines fall back to the core's default configuration when not set elsewhere.
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

package VX_wb_pkg;

    localparam int UUID_W = `UUID_BITS;
    localparam int NT_W   = `NUM_THREADS;
    localparam int NW_W   = `NW_BITS;
    localparam int NR_W   = `NR_BITS;
    localparam int PC_W   = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [UUID_W-1:0]            uuid;
        logic [NT_W-1:0]              tmask;
        logic [NW_W-1:0]              wid;
        logic [PC_W-1:0]              PC;
        logic [NR_W-1:0]              rd;
        logic [NT_W-1:0][DATA_W-1:0]  data;
        logic                         eop;
    } wb_beat_t;

    localparam int BEAT_W = $bits(wb_beat_t);

    // Next round-robin index after idx, wrapping at n.
    function automatic int unsigned wb_wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry elastic buffer: accepts whenever fewer than two entries are held, so the
// upstream ready never depends on the downstream ready in the same cycle.
module wb_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [1:0][WIDTH-1:0] r_mem;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign in_ready  = (r_count != 2'd2) & ~reset;
    assign out_valid = (r_count != 2'd0) & ~reset;
    assign out_data  = r_mem[r_rd_ptr];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Occupancy and pointer tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: contents are ignored while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Round-robin writeback arbiter with packet-granular locking, feeding a 2-entry skid
// buffer that drives the single register-file writeback port.
module vx_writeback_arbiter
    import VX_wb_pkg::*;
#(
    parameter int NUM_REQS = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_REQS-1:0]                         in_valid,
    input  logic [NUM_REQS-1:0][UUID_W-1:0]             in_uuid,
    input  logic [NUM_REQS-1:0][NT_W-1:0]               in_tmask,
    input  logic [NUM_REQS-1:0][NW_W-1:0]               in_wid,
    input  logic [NUM_REQS-1:0][PC_W-1:0]               in_PC,
    input  logic [NUM_REQS-1:0][NR_W-1:0]               in_rd,
    input  logic [NUM_REQS-1:0][NT_W-1:0][DATA_W-1:0]   in_data,
    input  logic [NUM_REQS-1:0]                         in_eop,
    output logic [NUM_REQS-1:0]                         in_ready,
    output logic                                        out_valid,
    output logic [UUID_W-1:0]                           out_uuid,
    output logic [NT_W-1:0]                             out_tmask,
    output logic [NW_W-1:0]                             out_wid,
    output logic [PC_W-1:0]                             out_PC,
    output logic [NR_W-1:0]                             out_rd,
    output logic [NT_W-1:0][DATA_W-1:0]                 out_data,
    output logic                                        out_eop,
    input  logic                                        out_ready,
    output logic [31:0]                                 perf_stalls
);

    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_lock_idx;
    logic                r_locked;
    logic [31:0]         r_stalls;

    logic [NUM_REQS-1:0] w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_found;
    logic [IDX_W:0]      w_cand;
    logic                w_buf_ready;
    logic                w_buf_valid;
    logic                w_push;
    wb_beat_t            w_in_beat;
    wb_beat_t            w_out_beat;

    // Grant selection: locked requester only, otherwise first valid from rr_ptr upward.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        if (r_locked) begin
            w_grant_idx = r_lock_idx;
            w_found     = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
                if (w_cand >= (IDX_W+1)'(NUM_REQS)) begin
                    w_cand = w_cand - (IDX_W+1)'(NUM_REQS);
                end else begin
                    w_cand = w_cand;
                end
                if (!w_found && in_valid[w_cand[IDX_W-1:0]]) begin
                    w_found     = 1'b1;
                    w_grant_idx = w_cand[IDX_W-1:0];
                end else begin
                    w_found     = w_found;
                end
            end
        end
        if (w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    assign in_ready = w_grant & {NUM_REQS{w_buf_ready}};
    assign w_push   = |(in_valid & in_ready);

    // Pack the granted requester's fields into one beat.
    always_comb begin
        w_in_beat       = '0;
        w_in_beat.uuid  = in_uuid[w_grant_idx];
        w_in_beat.tmask = in_tmask[w_grant_idx];
        w_in_beat.wid   = in_wid[w_grant_idx];
        w_in_beat.PC    = in_PC[w_grant_idx];
        w_in_beat.rd    = in_rd[w_grant_idx];
        w_in_beat.data  = in_data[w_grant_idx];
        w_in_beat.eop   = in_eop[w_grant_idx];
    end

    // Lock holds a requester across a multi-beat packet; priority rotates only on eop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else if (w_push) begin
            if (w_in_beat.eop) begin
                r_locked <= 1'b0;
                r_rr_ptr <= IDX_W'(wb_wrap_inc(32'(w_grant_idx), 32'(NUM_REQS)));
            end else begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_grant_idx;
            end
        end
    end

    wb_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_push),
        .in_data   (w_in_beat),
        .in_ready  (w_buf_ready),
        .out_valid (w_buf_valid),
        .out_data  (w_out_beat),
        .out_ready (out_ready)
    );

    // Backpressure cycle counter, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stalls <= 32'd0;
        end else if (w_buf_valid && !out_ready) begin
            r_stalls <= r_stalls + 32'd1;
        end
    end

    assign out_valid   = w_buf_valid;
    assign out_uuid    = w_out_beat.uuid;
    assign out_tmask   = w_out_beat.tmask;
    assign out_wid     = w_out_beat.wid;
    assign out_PC      = w_out_beat.PC;
    assign out_rd      = w_out_beat.rd;
    assign out_data    = w_out_beat.data;
    assign out_eop     = w_out_beat.eop;
    assign perf_stalls = r_stalls;

endmodule
